// File: rtl/shift_seq.sv
// Multi-cycle rotate/shift sequencer: steps a working register one bit per clock
// for ROR, ROL, SHR, SHL and SHRA, then presents the result with a one-cycle done pulse.
module shift_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] amount,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {
    OP_ROR  = 3'b000,
    OP_ROL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHRA = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  op_t                op_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_step;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] start_n;
  logic               op_legal;
  logic               accept;

  // Only the low SHAMT_W bits of amount matter; the rest wrap away.
  logic unused_amount_hi;
  assign unused_amount_hi = ^amount[WIDTH-1:SHAMT_W];

  // One 1-bit step of the latched operation applied to the working register.
  always_comb begin
    // NOTE: a default before the case keeps this block purely combinational (no latch).
    work_step = work;
    case (op_q)
      OP_ROR:  work_step = {work[0], work[WIDTH-1:1]};
      OP_ROL:  work_step = {work[WIDTH-2:0], work[WIDTH-1]};
      OP_SHR:  work_step = {1'b0, work[WIDTH-1:1]};
      OP_SHL:  work_step = {work[WIDTH-2:0], 1'b0};
      OP_SHRA: work_step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: work_step = work;
    endcase
  end

  // Illegal opcodes degenerate to a zero-length operation that returns the operand.
  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_ROR, OP_ROL, OP_SHR, OP_SHL, OP_SHRA: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
    start_n = op_legal ? amount[SHAMT_W-1:0] : '0;
    accept  = start && (state != SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments everywhere here so every register sees pre-edge values.
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      work   <= '0;
      op_q   <= OP_ROR;
    end else begin
      done <= 1'b0;
      case (state)
        SHIFT: begin
          work  <= work_step;
          count <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= work_step;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request, so DONE can chain back-to-back.
          if (accept) begin
            op_q  <= op_t'(op);
            work  <= operand;
            count <= start_n;
            if (start_n == '0) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= operand;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: the driver pushes model-predicted results and done
// timing; an independent monitor pops and compares whenever done is seen.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] amount;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          done_edge;
    int          n;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          edge_cnt  = 0;
  int          last_edge = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          busy_run  = 0;
  logic [31:0] hold_res  = '0;
  bit          hold;

  shift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .amount  (amount),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: whole-word arithmetic on the effective amount.
  function automatic int ref_n(input logic [2:0] o, input logic [31:0] a);
    if (o > 3'd4) return 0;
    return int'(a % 32);
  endfunction

  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] x);
    logic [63:0] d;
    int          n;
    n = ref_n(o, a);
    case (o)
      3'd0: begin d = {x, x} >> n; return d[31:0]; end
      3'd1: begin d = {x, x} << n; return d[63:32]; end
      3'd2: return x >> n;
      3'd3: return x << n;
      3'd4: return $signed(x) >>> n;
      default: return x;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] x);
    exp_t e;
    start       = 1'b1;
    op          = o;
    amount      = a;
    operand     = x;
    e.n         = ref_n(o, a);
    e.res       = ref_res(o, a, x);
    e.done_edge = edge_cnt + 1 + e.n;
    sb.push_back(e);
    last_edge = e.done_edge;
  endtask

  // Let the accepting edge pass, then scramble inputs that must no longer matter.
  task automatic finish_op(input bit keep_start);
    step();
    if (!keep_start) start = 1'b0;
    op      = 3'($urandom_range(0, 7));
    amount  = $urandom;
    operand = $urandom;
  endtask

  task automatic wait_done();
    while (edge_cnt < last_edge) step();
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] x);
    issue(o, a, x);
    finish_op(1'b0);
    wait_done();
  endtask

  // Monitor: result must only move on done, and done must match the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
      hold_res = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (result 0x%08h) at edge %0d",
                 result, edge_cnt);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("done_edge", 32'(edge_cnt), 32'(mon_e.done_edge));
        check("busy_cycles", 32'(busy_run), 32'(mon_e.n));
        hold_res = mon_e.res;
      end
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      check("result_hold", result, hold_res);
    end
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = '0;
    amount  = '0;
    operand = '0;
    step();
    step();
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    step();
    reset = 1'b0;
    step();

    run_op(3'd0, 32'd1, 32'h8000_0001);
    run_op(3'd1, 32'd36, 32'h1234_5678);
    run_op(3'd4, 32'd31, 32'h8000_0000);
    run_op(3'd2, 32'd31, 32'h8000_0000);
    run_op(3'd3, 32'd31, 32'h0000_0001);
    run_op(3'd0, 32'd0, 32'hDEAD_BEEF);
    run_op(3'd7, 32'd5, 32'hDEAD_BEEF);
    run_op(3'd2, 32'd32, 32'hCAFE_F00D);

    // Mid-operation start pulse is ignored; then start held into DONE chains a new op.
    issue(3'd0, 32'd6, 32'hA5A5_0F0F);
    finish_op(1'b0);
    start = 1'b1;
    step();
    start   = 1'b0;
    op      = 3'd2;
    amount  = 32'd2;
    operand = 32'h0000_000F;
    step();
    start = 1'b1;
    wait_done();
    issue(3'd2, 32'd2, 32'h0000_000F);
    finish_op(1'b0);
    wait_done();
    step();

    // Reset during a ROR by 10 aborts it with no done pulse afterwards.
    issue(3'd0, 32'd10, $urandom);
    finish_op(1'b0);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    repeat (15) step();
    run_op(3'd1, 32'd1, 32'h0000_0001);

    // Random operations, mixing idle gaps with start held high back-to-back.
    for (int i = 0; i < 150; i++) begin
      hold = 1'($urandom_range(0, 1));
      issue(3'($urandom_range(0, 7)), $urandom, $urandom);
      finish_op(hold);
      wait_done();
      if (!hold) repeat ($urandom_range(0, 2)) step();
    end
    start = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle sequencer for the CPU's rotate/shift datapath. Performs ROR, ROL, SHR, SHL and SHRA by stepping a 32-bit working register one bit per clock.
- Accepts a start request with opcode, amount and operand, then returns the result with a one-cycle done pulse.
- Sits beside the combinational ALU. The control unit uses it where a single-bit shifter is shared or timing forbids a full barrel rotator.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, amount bits used (log2 WIDTH); the effective amount is amount mod WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- op  input  3  000 ROR, 001 ROL, 010 SHR (logical), 011 SHL, 100 SHRA (arithmetic); 101-111 illegal.
- amount  input  WIDTH  shift/rotate count; only bits [SHAMT_W-1:0] are used.
- operand  input  WIDTH  value to transform.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  WIDTH  registered result; held until the next accepted start.

Behaviour:
- Reset (sync, takes priority over everything):
  - state=IDLE, busy=0, done=0, result=0, count=0.
  - Reset asserted mid-operation aborts the operation; no done is produced.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - start is accepted at a rising edge when state is IDLE or DONE, which allows back-to-back operation.
  - start is ignored in SHIFT; there is no queueing.
- On accepted start at edge k:
  - Latch op, operand into the working register, and n=amount[SHAMT_W-1:0].
  - Illegal op forces n=0 and makes the result equal to operand.
  - If n==0, next state is DONE; otherwise next state is SHIFT with count=n.
- SHIFT, each edge: apply one 1-bit step to the working register, then count=count-1. When count==1 at the edge, next state is DONE.
  - ROR: {w[0], w[WIDTH-1:1]}
  - ROL: {w[WIDTH-2:0], w[WIDTH-1]}
  - SHR: {1'b0, w[WIDTH-1:1]}
  - SHL: {w[WIDTH-2:0], 1'b0}
  - SHRA: {w[WIDTH-1], w[WIDTH-1:1]}
- DONE: done=1 for exactly one cycle and result=working register.
  - Next state is IDLE, unless start is present, which re-enters per the start rules.
- Latency:
  - done is high in the cycle following edge k+n, for every n in 0..WIDTH-1.
  - busy is high for exactly n cycles.
- result:
  - Updates only on entry to DONE; it is stable in IDLE and throughout the following SHIFT.
  - It is not overwritten by the in-progress working register.
- Boundary conditions:
  - Amounts of 32 or more wrap modulo 32; amount=32 behaves as 0.
  - n=31 gives maximum busy time, 31 cycles.
  - Operand and op changing during SHIFT have no effect.
  - start held high continuously gives one operation per n+1 cycles.

Test Plan:
1. ROR, operand=0x80000001, amount=1, start at edge k -> busy for 1 cycle; done in the cycle after edge k+1; result=0xC0000000.
2. ROL, operand=0x12345678, amount=36 (wraps to 4) -> busy for 4 cycles; result=0x23456781; done pulses for exactly one cycle.
3. SHRA, operand=0x80000000, amount=31 -> result=0xFFFFFFFF after 31 busy cycles. Repeat with SHR -> result=0x00000001. Repeat with SHL on 0x00000001, amount=31 -> result=0x80000000.
4. amount=0, op=ROR, operand=0xDEADBEEF -> busy never asserts; done in the cycle after the start edge; result=0xDEADBEEF. Repeat with op=3'b111, amount=5 -> same timing; result=operand.
5. Second start pulsed mid-SHIFT -> ignored; first result is unaffected. start held through DONE with new operand=0x0000000F, SHR by 2 -> accepted back-to-back; result=0x00000003.
6. reset asserted during SHIFT of a ROR by 10 -> the next cycle shows IDLE, busy=0, done=0, result=0, with no done pulse afterward. A subsequent ROL of 0x1 by 1 -> result=0x00000002.
